// File: rtl/signed_bcd_converter.sv
`timescale 1ns/1ps
// signed_bcd_converter
// Converts a signed 8-bit value into a sign flag and three BCD digits.
// It uses an iterative double-dabble engine with a start/busy/done handshake.
// The digits stay registered and stable between conversions, so the
// seven-segment decoder downstream needs no divide/modulo logic.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | eight add-3/shift iterations, one per edge; cnt counts 0..7
module signed_bcd_converter (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] value,
    output logic       busy,
    output logic       done,
    output logic       sign,
    output logic [3:0] bcd_hun,
    output logic [3:0] bcd_ten,
    output logic [3:0] bcd_one
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic [7:0]  mag;
    logic [11:0] scratch;
    logic [11:0] scratch_adj;
    logic [11:0] scratch_nxt;
    logic        sign_q;
    logic        last_iter;

    assign last_iter = (state == SHIFT) && (cnt == 3'd7);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start is only looked at in IDLE, so a start during SHIFT is dropped
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = SHIFT;
            SHIFT:   if (cnt == 3'd7) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: busy covers exactly the eight shift cycles
    always_comb begin
        busy = (state == SHIFT);
    end

    // Add-3 correction on every nibble >= 5, then the next shifted scratch value
    always_comb begin
        scratch_adj[3:0]   = (scratch[3:0]   >= 4'd5) ? scratch[3:0]   + 4'd3 : scratch[3:0];
        scratch_adj[7:4]   = (scratch[7:4]   >= 4'd5) ? scratch[7:4]   + 4'd3 : scratch[7:4];
        scratch_adj[11:8]  = (scratch[11:8]  >= 4'd5) ? scratch[11:8]  + 4'd3 : scratch[11:8];
        scratch_nxt        = {scratch_adj[10:0], mag[7]};
    end

    // Conversion datapath: operand capture in IDLE, one iteration per SHIFT edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= 3'd0;
            mag     <= 8'd0;
            scratch <= 12'd0;
            sign_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q  <= value[7];
                        // -128 negates to 0x80, which is still the right unsigned magnitude
                        mag     <= value[7] ? (~value + 8'd1) : value;
                        scratch <= 12'd0;
                        cnt     <= 3'd0;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_nxt;
                    mag     <= {mag[6:0], 1'b0};
                    cnt     <= cnt + 3'd1;
                end
                default: begin
                    cnt <= 3'd0;
                end
            endcase
        end
    end

    // Result registers: load on the final iteration edge only, otherwise hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done    <= 1'b0;
            sign    <= 1'b0;
            bcd_hun <= 4'd0;
            bcd_ten <= 4'd0;
            bcd_one <= 4'd0;
        end else begin
            done <= last_iter;
            if (last_iter) begin
                // A zero magnitude can only come from a zero value, so there is no negative zero
                sign    <= sign_q;
                bcd_hun <= scratch_nxt[11:8];
                bcd_ten <= scratch_nxt[7:4];
                bcd_one <= scratch_nxt[3:0];
            end
        end
    end

endmodule

// File: tb/tb_signed_bcd_converter.sv
`timescale 1ns/1ps
// Testbench for signed_bcd_converter.
// Directed and random conversions are checked against a plain-arithmetic reference.
module tb_signed_bcd_converter;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] value;
    logic       busy;
    logic       done;
    logic       sign;
    logic [3:0] bcd_hun;
    logic [3:0] bcd_ten;
    logic [3:0] bcd_one;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] last_out = 16'h0;

    signed_bcd_converter dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .value   (value),
        .busy    (busy),
        .done    (done),
        .sign    (sign),
        .bcd_hun (bcd_hun),
        .bcd_ten (bcd_ten),
        .bcd_one (bcd_one)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {sign, hundreds, tens, units} computed from the integer value
    function automatic logic [15:0] model(input logic [7:0] v);
        int x;
        logic s;
        x = int'($signed(v));
        s = (x < 0);
        if (x < 0) x = -x;
        return {3'b000, s, 4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    function automatic logic [15:0] outs();
        return {3'b000, sign, bcd_hun, bcd_ten, bcd_one};
    endfunction

    task automatic do_conv(input logic [7:0] v);
        logic [15:0] exp;
        int lat;
        exp = model(v);
        lat = -1;
        @(negedge clk);
        value = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        value = 8'($urandom);
        check("busy_after_start", {15'd0, busy}, 16'd1);
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            check("busy_done_excl", {15'd0, busy & done}, 16'd0);
            if (done) begin
                lat = n;
                break;
            end
            check("hold_outputs", outs(), last_out);
        end
        check("done_latency", lat[15:0], 16'd8);
        check("result", outs(), exp);
        check("busy_at_done", {15'd0, busy}, 16'd0);
        last_out = exp;
        @(posedge clk);
        #1;
        check("done_single", {15'd0, done}, 16'd0);
    endtask

    initial begin
        int dones;
        int prev;
        int got;
        logic [15:0] cap;

        reset = 1'b1;
        start = 1'b0;
        value = 8'h00;
        #12;
        check("reset_outputs", outs(), 16'h0);
        check("reset_busy_done", {14'd0, busy, done}, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_no_start", {14'd0, busy, done}, 16'd0);
        check("idle_outputs", outs(), 16'h0);

        do_conv(8'h7F);
        do_conv(8'h80);
        do_conv(8'hFF);
        do_conv(8'h00);
        do_conv(8'hF6);

        // A second start in the middle of a conversion must be dropped
        dones = 0;
        cap = 16'h0;
        @(negedge clk);
        value = 8'h2A;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            start = (n == 3);
            if (n == 3) value = 8'h05;
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                cap = outs();
            end
        end
        check("ignore_done_count", dones[15:0], 16'd1);
        check("ignore_result", cap, model(8'h2A));
        last_out = model(8'h2A);

        // Asynchronous reset partway through a conversion
        @(negedge clk);
        value = 8'h64;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_outputs", outs(), 16'h0);
        check("async_rst_busy_done", {14'd0, busy, done}, 16'd0);
        dones = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        check("async_rst_no_done", dones[15:0], 16'd0);
        last_out = 16'h0;
        do_conv(8'h64);

        // start held high: back-to-back conversions with alternating operands
        got = 0;
        prev = 0;
        @(negedge clk);
        value = 8'h0C;
        start = 1'b1;
        for (int cyc = 1; cyc <= 80 && got < 6; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                check("b2b_result", outs(), model((got % 2) ? 8'hF4 : 8'h0C));
                if (got == 0) check("b2b_first_lat", cyc[15:0], 16'd9);
                else          check("b2b_period", 16'(cyc - prev), 16'd9);
                prev = cyc;
                got++;
                value = (got % 2) ? 8'hF4 : 8'h0C;
                if (got == 6) start = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b_count", got[15:0], 16'd6);
        last_out = model(8'hF4);

        // Random operands with random idle gaps
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_conv(8'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
